bus_sched: RTL and testbench
============================

BUS_SCHED -- requirements
Module: bus_sched

Interface
REQ-001 Parameter N, default 4, number of requesters sharing the resource (N >= 2).
REQ-002 Parameter TMO, default 16, maximum grant tenure in cycles (0 disables timeout).
REQ-003 Parameter IDW, default $clog2(N), width of owner index.
REQ-004 clk_i  input  1  single system clock; all state changes on rising edge.
REQ-005 rst_i  input  1  reset; asynchronous, active-high.
REQ-006 req_i  input  N  per-requester request level; held high while access is wanted.
REQ-007 done_i  input  N  per-requester end-of-transaction strobe; only the bit of the current owner is honoured.
REQ-008 gnt_o  output  N  registered one-hot grant (all-zero when no owner).
REQ-009 owner_o  output  IDW  index of current owner, valid while busy_o is high.
REQ-010 busy_o  output  1  high while the FSM is in GRANT.
REQ-011 timeout_o  output  1  one-cycle pulse when a grant is revoked by timeout.

Function
REQ-012 FSM states SHALL be IDLE, GRANT and RELEASE.
REQ-013 IDLE: if any req_i bit is high, pick winner round-robin starting at (ptr+1) mod N; go to GRANT; gnt_o, owner_o and busy_o become valid the next cycle (1-cycle request-to-grant latency).
REQ-014 On entering GRANT, ptr SHALL load the winner index; tenure counter SHALL load 0.
REQ-015 GRANT: counter SHALL increment each cycle, saturating at TMO.
REQ-016 GRANT exits to RELEASE when done_i[owner] is high, when req_i[owner] is low, or when counter equals TMO-1 with TMO>0.
REQ-017 timeout_o SHALL pulse only on timeout exit; done_i[owner] or dropped request in the same cycle takes precedence (no pulse).
REQ-018 RELEASE: gnt_o all-zero and busy_o low for exactly one turnaround cycle, then IDLE; no two grants SHALL ever overlap or be adjacent.
REQ-019 done_i bits of non-owners and done_i in IDLE/RELEASE SHALL be ignored.
REQ-020 Requests arriving during GRANT/RELEASE SHALL be considered only in the next IDLE evaluation; no request is dropped while held.
REQ-021 With all N requesting continuously, grants SHALL rotate ptr+1, ptr+2, ... wrapping N-1 -> 0 (starvation-free).
REQ-022 Worst-case wait per requester SHALL be (N-1)*(TMO+2)+1 cycles when TMO>0.

Reset
REQ-023 On rst_i assertion, without waiting for clk_i: state IDLE, gnt_o 0, owner_o 0, busy_o 0, timeout_o 0, counter 0, ptr N-1 (requester 0 has first priority).
REQ-024 Reset asserted mid-GRANT SHALL revoke the grant immediately; first grant after release follows REQ-013 from the reset state.

Structure
REQ-025 State encodings and arbitration localparams SHALL reside in shared package arb_pkg.
REQ-026 Round-robin winner selection SHALL be a combinational sub-module rr_pick (inputs req, ptr; outputs one-hot and index).
REQ-027 All outputs SHALL be driven directly from flops.

Verification
REQ-028 Reset, then req_i=4'b0100 at cycle 0 -> gnt_o=4'b0100, owner_o=2, busy_o=1 at cycle 1.
REQ-029 req_i=4'b1111 held, done_i[owner] pulsed 2 cycles after each grant -> grant order 0,1,2,3,0, one zero cycle between grants.
REQ-030 TMO=16, single requester 1 holds req without done -> gnt_o=4'b0010 for 16 cycles, timeout_o pulse on the release cycle, regrant to 1 after RELEASE.
REQ-031 done_i[owner] and timeout in same cycle -> release, timeout_o stays 0; done_i on non-owner bit -> no effect.
REQ-032 rst_i asserted between clock edges during GRANT -> gnt_o=0 immediately; after deassertion with req_i=4'b1001 -> requester 0 granted first.
REQ-033 Owner drops req_i mid-tenure -> RELEASE next cycle, no timeout_o, next requester granted after turnaround.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared arbitration types and constants for the bus scheduler and its round-robin picker.
package arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_t;

    localparam int ARB_DEF_N   = 4;
    localparam int ARB_DEF_TMO = 16;

    // Tenure counter must hold values 0..TMO inclusive.
    function automatic int tenureWidth(input int tmo);
        return (tmo < 1) ? 1 : $clog2(tmo + 1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester found scanning from (ptr+1) mod N.
module rr_pick #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   i_req,
    input  logic [IDW-1:0] i_ptr,
    output logic [N-1:0]   o_onehot,
    output logic [IDW-1:0] o_idx
);

    logic [IDW-1:0] w_cand;
    logic           w_found;

    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        w_found  = 1'b0;
        w_cand   = '0;
        for (int i = 1; i <= N; i++) begin
            w_cand = IDW'((int'(i_ptr) + i) % N);
            if (!w_found && i_req[w_cand]) begin
                w_found          = 1'b1;
                o_onehot[w_cand] = 1'b1;
                o_idx            = w_cand;
            end
        end
    end

endmodule

// File: rtl/bus_sched.sv
// Round-robin bus scheduler: grants one requester at a time with bounded tenure
// and a one-cycle turnaround between grants.
module bus_sched
    import arb_pkg::*;
#(
    parameter int N   = ARB_DEF_N,
    parameter int TMO = ARB_DEF_TMO,
    parameter int IDW = $clog2(N)
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic [N-1:0]   req_i,
    input  logic [N-1:0]   done_i,
    output logic [N-1:0]   gnt_o,
    output logic [IDW-1:0] owner_o,
    output logic           busy_o,
    output logic           timeout_o
);

    localparam int CW = tenureWidth(TMO);

    arb_state_t     r_state;
    arb_state_t     w_nextState;
    logic [N-1:0]   r_gnt;
    logic [IDW-1:0] r_owner;
    logic [IDW-1:0] r_ptr;
    logic           r_busy;
    logic           r_timeout;
    logic [CW-1:0]  r_tenureCnt;

    logic [N-1:0]   w_pickOnehot;
    logic [IDW-1:0] w_pickIdx;
    logic           w_anyReq;
    logic           w_userExit;
    logic           w_timeoutHit;

    assign w_anyReq = |req_i;

    rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .i_req    (req_i),
        .i_ptr    (r_ptr),
        .o_onehot (w_pickOnehot),
        .o_idx    (w_pickIdx)
    );

    always_comb begin
        w_nextState  = r_state;
        w_userExit   = 1'b0;
        w_timeoutHit = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_anyReq) w_nextState = ST_GRANT;
            end
            ST_GRANT: begin
                w_userExit   = done_i[r_owner] || !req_i[r_owner];
                w_timeoutHit = (TMO > 0) && (r_tenureCnt == CW'(TMO - 1));
                if (w_userExit || w_timeoutHit) w_nextState = ST_RELEASE;
            end
            ST_RELEASE: w_nextState = ST_IDLE;
            default:    w_nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= ST_IDLE;
        else       r_state <= w_nextState;
    end

    // Pointer resets to N-1 so requester 0 wins the first arbitration.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_gnt       <= '0;
            r_owner     <= '0;
            r_ptr       <= IDW'(N - 1);
            r_busy      <= 1'b0;
            r_timeout   <= 1'b0;
            r_tenureCnt <= '0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_anyReq) begin
                        r_gnt       <= w_pickOnehot;
                        r_owner     <= w_pickIdx;
                        r_ptr       <= w_pickIdx;
                        r_busy      <= 1'b1;
                        r_tenureCnt <= '0;
                    end
                end
                ST_GRANT: begin
                    if (w_userExit || w_timeoutHit) begin
                        r_gnt     <= '0;
                        r_busy    <= 1'b0;
                        r_timeout <= w_timeoutHit && !w_userExit;
                    end else if (r_tenureCnt != CW'(TMO)) begin
                        r_tenureCnt <= r_tenureCnt + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign gnt_o     = r_gnt;
    assign owner_o   = r_owner;
    assign busy_o    = r_busy;
    assign timeout_o = r_timeout;

endmodule

// File: tb/tb_bus_sched.sv
// Self-checking bench for bus_sched: directed scenarios followed by random traffic,
// all compared against a transaction-level arbitration model.
module tb_bus_sched;

    localparam int N   = 4;
    localparam int TMO = 16;
    localparam int IDW = 2;
    // A request raised during the turnaround cycle is first evaluated one cycle later.
    localparam int WAIT_LIMIT = (N - 1) * (TMO + 2) + 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N-1:0]   done;
    logic [N-1:0]   gnt;
    logic [IDW-1:0] owner;
    logic           busy;
    logic           tmo;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int   mOwner;
    int   mHeld;
    int   mGap;
    int   mLast;
    logic mTimeout;

    int           waitStart [N];
    logic [N-1:0] prevGnt;
    int           grantLog [$];
    int           held;
    logic [N-1:0] rq;
    logic [N-1:0] dn;
    logic [N-1:0] rNew;
    logic [N-1:0] dNew;
    int           expOrder [5] = '{0, 1, 2, 3, 0};

    always #5 clk = ~clk;

    bus_sched #(
        .N   (N),
        .TMO (TMO),
        .IDW (IDW)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .req_i     (req),
        .done_i    (done),
        .gnt_o     (gnt),
        .owner_o   (owner),
        .busy_o    (busy),
        .timeout_o (tmo)
    );

    function automatic void modelReset();
        mOwner   = -1;
        mHeld    = 0;
        mGap     = 0;
        mLast    = N - 1;
        mTimeout = 1'b0;
    endfunction

    // One clock of arbitration: an owner keeps the bus until done, drop, or TMO cycles held;
    // one dead cycle follows; then the first requester after the last winner is chosen.
    function automatic void modelStep(input logic [N-1:0] r, input logic [N-1:0] d);
        logic found;
        mTimeout = 1'b0;
        if (mOwner >= 0) begin
            if (d[mOwner] || !r[mOwner] || (TMO > 0 && mHeld == TMO)) begin
                mTimeout = r[mOwner] && !d[mOwner];
                mOwner   = -1;
                mGap     = 1;
            end else begin
                mHeld++;
            end
        end else if (mGap > 0) begin
            mGap--;
        end else if (r != '0) begin
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
                if (!found && r[(mLast + k) % N]) begin
                    found  = 1'b1;
                    mOwner = (mLast + k) % N;
                end
            end
            mHeld = 1;
            mLast = mOwner;
        end
    endfunction

    task automatic expectVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("[TB] FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [N-1:0] eg;
        eg = '0;
        if (mOwner >= 0) eg[mOwner] = 1'b1;
        total++;
        assert (gnt === eg) else begin
            bad++;
            $error("[TB] FAIL %s gnt got=%b exp=%b", tag, gnt, eg);
        end
        total++;
        assert (busy === (mOwner >= 0)) else begin
            bad++;
            $error("[TB] FAIL %s busy got=%b exp=%b", tag, busy, (mOwner >= 0));
        end
        if (mOwner >= 0) begin
            total++;
            assert (owner === IDW'(mOwner)) else begin
                bad++;
                $error("[TB] FAIL %s owner got=%0d exp=%0d", tag, owner, mOwner);
            end
        end
        total++;
        assert (tmo === mTimeout) else begin
            bad++;
            $error("[TB] FAIL %s timeout got=%b exp=%b", tag, tmo, mTimeout);
        end
        total++;
        assert ($onehot0(gnt) && !(prevGnt != '0 && gnt != '0 && gnt != prevGnt)) else begin
            bad++;
            $error("[TB] FAIL %s overlap prev=%b now=%b", tag, prevGnt, gnt);
        end
        for (int i = 0; i < N; i++) begin
            if (gnt[i] && waitStart[i] >= 0) begin
                total++;
                assert (cyc - waitStart[i] <= WAIT_LIMIT) else begin
                    bad++;
                    $error("[TB] FAIL %s wait%0d got=%0d max=%0d", tag, i, cyc - waitStart[i], WAIT_LIMIT);
                end
                waitStart[i] = -1;
            end
        end
        if (gnt != '0 && prevGnt == '0) begin
            for (int i = 0; i < N; i++) if (gnt[i]) grantLog.push_back(i);
        end
        prevGnt = gnt;
    endtask

    task automatic applyStimulus(input logic [N-1:0] r, input logic [N-1:0] d);
        req  = r;
        done = d;
        for (int i = 0; i < N; i++) begin
            if (!r[i] || gnt[i])     waitStart[i] = -1;
            else if (waitStart[i] < 0) waitStart[i] = cyc;
        end
    endtask

    task automatic stepClock(input string tag);
        rq = req;
        dn = done;
        @(posedge clk);
        if (rst) modelReset();
        else     modelStep(rq, dn);
        #1;
        cyc++;
        checkOutput(tag);
    endtask

    task automatic clearTracking();
        modelReset();
        prevGnt = '0;
        for (int i = 0; i < N; i++) waitStart[i] = -1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus('0, '0);
        clearTracking();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst  = 1'b1;
        req  = '0;
        done = '0;
        clearTracking();
        repeat (2) @(posedge clk);
        #1;
        expectVal("reset gnt", 32'(gnt), 32'd0);
        expectVal("reset owner", 32'(owner), 32'd0);
        expectVal("reset busy", 32'(busy), 32'd0);
        expectVal("reset timeout", 32'(tmo), 32'd0);
        rst = 1'b0;

        $display("[TB] single request latency");
        applyStimulus(4'b0100, '0);
        stepClock("req028");
        expectVal("req028 gnt", 32'(gnt), 32'b0100);
        expectVal("req028 owner", 32'(owner), 32'd2);
        expectVal("req028 busy", 32'(busy), 32'd1);
        applyStimulus('0, '0);
        repeat (3) stepClock("req028 drain");

        $display("[TB] rotation with all requesting");
        doReset();
        grantLog.delete();
        held = 0;
        applyStimulus(4'b1111, '0);
        for (int c = 0; c < 80 && grantLog.size() < 5; c++) begin
            stepClock("req029");
            if (gnt != '0) held++;
            else           held = 0;
            applyStimulus(4'b1111, (held == 2) ? gnt : '0);
        end
        expectVal("req029 grants", 32'(grantLog.size()), 32'd5);
        for (int k = 0; k < 5; k++) begin
            if (k < grantLog.size()) expectVal("req029 order", 32'(grantLog[k]), 32'(expOrder[k]));
        end
        applyStimulus('0, '0);
        repeat (3) stepClock("req029 drain");

        $display("[TB] timeout tenure");
        applyStimulus(4'b0010, '0);
        stepClock("req030 arb");
        expectVal("req030 gnt", 32'(gnt), 32'b0010);
        held = 0;
        while (gnt == 4'b0010 && held < 40) begin
            held++;
            stepClock("req030 hold");
        end
        expectVal("req030 tenure", 32'(held), 32'(TMO));
        expectVal("req030 pulse", 32'(tmo), 32'd1);
        stepClock("req030 idle");
        stepClock("req030 regrant");
        expectVal("req030 regrant", 32'(gnt), 32'b0010);

        $display("[TB] done beats timeout, foreign done ignored");
        held = 0;
        while (gnt == 4'b0010 && held < 40) begin
            held++;
            applyStimulus(4'b0010, (mHeld == TMO) ? 4'b0010 : 4'b1101);
            stepClock("req031");
        end
        expectVal("req031 tenure", 32'(held), 32'(TMO));
        expectVal("req031 no pulse", 32'(tmo), 32'd0);
        applyStimulus('0, '0);
        repeat (2) stepClock("req031 drain");

        $display("[TB] owner drops request");
        applyStimulus(4'b0110, '0);
        stepClock("req033 arb");
        expectVal("req033 gnt", 32'(gnt), 32'b0100);
        stepClock("req033 hold");
        stepClock("req033 hold");
        applyStimulus(4'b0010, '0);
        stepClock("req033 drop");
        expectVal("req033 rel gnt", 32'(gnt), 32'd0);
        expectVal("req033 rel busy", 32'(busy), 32'd0);
        expectVal("req033 rel timeout", 32'(tmo), 32'd0);
        stepClock("req033 idle");
        stepClock("req033 next");
        expectVal("req033 next gnt", 32'(gnt), 32'b0010);

        $display("[TB] asynchronous reset mid-grant");
        #3;
        rst = 1'b1;
        #1;
        expectVal("req032 async gnt", 32'(gnt), 32'd0);
        expectVal("req032 async busy", 32'(busy), 32'd0);
        clearTracking();
        applyStimulus(4'b1001, '0);
        @(posedge clk);
        #4;
        rst = 1'b0;
        stepClock("req032 first");
        expectVal("req032 gnt", 32'(gnt), 32'b0001);
        expectVal("req032 owner", 32'(owner), 32'd0);

        $display("[TB] random traffic");
        for (int c = 0; c < 800; c++) begin
            rNew = req;
            dNew = '0;
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 7) == 0) rNew[i] = ~rNew[i];
                if ($urandom_range(0, 7) == 0) dNew[i] = 1'b1;
            end
            applyStimulus(rNew, dNew);
            stepClock("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
